// File: rtl/pipeline_stall_ctrl_pkg.sv
// pipeline_stall_ctrl_pkg: stage hold encodings and sequencer state
// shared by the stall controller and anything decoding its hold vector.
package pipeline_stall_ctrl_pkg;

    typedef enum int {ST_PC, ST_IFID, ST_IDEX, ST_EXMEM, ST_MEMWB, ST_WB} stage_e;

    // A hold on stage k also holds every stage upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'((1 << (int'(ST_IDEX) + 1)) - 1);
    localparam logic [5:0] STALL_EX   = 6'((1 << (int'(ST_EXMEM) + 1)) - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_FLUSH} state_e;

endpackage

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: stall/flush sequencer for the 5-stage pipeline;
// arbitrates flush > EX multi-cycle > ID load-use.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES  = 32,
    parameter int MADD_CYCLES = 2,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             ex_mc_req,
    input  logic             ex_mc_is_div,
    input  logic             flush_req,
    input  logic [31:0]      flush_pc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] ex_mc_phase,
    output logic             ex_mc_done
);

    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 2);
    localparam logic [CNT_W-1:0] MADD_LOAD = CNT_W'(MADD_CYCLES - 2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      new_pc_q, new_pc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            new_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            new_pc_q <= new_pc_d;
        end
    end

    // The request cycle in IDLE is the op's first EX cycle and DONE its last,
    // so BUSY spans N-2 cycles; a 2-cycle op goes straight from IDLE to DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        new_pc_d    = new_pc_q;
        stall       = STALL_NONE;
        flush       = 1'b0;
        ex_mc_done  = 1'b0;
        ex_mc_phase = '0;
        unique case (state_q)
            S_IDLE: begin
                if (flush_req) begin
                    flush    = 1'b1;
                    new_pc_d = flush_pc;
                    state_d  = S_FLUSH;
                end else if (ex_mc_req) begin
                    stall   = STALL_EX;
                    cnt_d   = ex_mc_is_div ? DIV_LOAD : MADD_LOAD;
                    state_d = (cnt_d == '0) ? S_DONE : S_BUSY;
                end else if (stallreq_id) begin
                    stall = STALL_ID;
                end
            end
            S_BUSY: begin
                ex_mc_phase = cnt_q + CNT_W'(1);
                if (flush_req) begin
                    flush    = 1'b1;
                    cnt_d    = '0;
                    new_pc_d = flush_pc;
                    state_d  = S_FLUSH;
                end else begin
                    stall   = STALL_EX;
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q <= CNT_W'(1)) ? S_DONE : S_BUSY;
                end
            end
            S_DONE: begin
                cnt_d = '0;
                if (flush_req) begin
                    flush    = 1'b1;
                    new_pc_d = flush_pc;
                    state_d  = S_FLUSH;
                end else begin
                    ex_mc_done = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            stall      = STALL_NONE;
            flush      = 1'b0;
            ex_mc_done = 1'b0;
        end
    end

    assign new_pc = new_pc_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: directed-vector bench with immediate assertions
// for the stall/flush sequencer.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, ex_mc_req, ex_mc_is_div, flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush, ex_mc_done;
    logic [31:0] new_pc;
    logic [5:0]  ex_mc_phase;
    int          n_chk = 0;
    int          n_err = 0;

    pipeline_stall_ctrl dut (
        .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_req(ex_mc_req),
        .ex_mc_is_div(ex_mc_is_div), .flush_req(flush_req), .flush_pc(flush_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .ex_mc_phase(ex_mc_phase), .ex_mc_done(ex_mc_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1; stallreq_id = 1'b1; ex_mc_req = 1'b1; ex_mc_is_div = 1'b1;
        flush_req = 1'b1; flush_pc = 32'hDEADBEEF;
        // reset with every request high
        for (int i = 0; i < 2; i++) begin
            tick(); settle();
            chk("rst_stall", 32'(stall), 32'h0);
            chk("rst_flush", 32'(flush), 32'h0);
            chk("rst_done", 32'(ex_mc_done), 32'h0);
            chk("rst_new_pc", new_pc, 32'h0);
        end
        rst = 1'b0; stallreq_id = 1'b0; ex_mc_req = 1'b0; flush_req = 1'b0;
        tick(); settle();
        chk("idle_stall", 32'(stall), 32'h00);
        chk("idle_phase", 32'(ex_mc_phase), 32'h0);
        // ID load-use for 3 cycles
        stallreq_id = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("id_stall", 32'(stall), 32'h07);
            chk("id_flush", 32'(flush), 32'h0);
            tick();
        end
        stallreq_id = 1'b0; settle();
        chk("id_release", 32'(stall), 32'h00);
        // div: 31 EX-hold cycles, done on cycle 32
        tick();
        ex_mc_req = 1'b1; ex_mc_is_div = 1'b1; stallreq_id = 1'b1; settle();
        chk("div_c1_stall", 32'(stall), 32'h0F);
        chk("div_c1_phase", 32'(ex_mc_phase), 32'h0);
        for (int i = 0; i < 30; i++) begin
            tick(); settle();
            chk("div_busy_stall", 32'(stall), 32'h0F);
            chk("div_busy_done", 32'(ex_mc_done), 32'h0);
            chk("div_busy_phase", 32'(ex_mc_phase), 32'(31 - i));
        end
        tick(); settle();
        chk("div_done", 32'(ex_mc_done), 32'h1);
        chk("div_done_stall", 32'(stall), 32'h00);
        chk("div_done_phase", 32'(ex_mc_phase), 32'h0);
        tick(); ex_mc_req = 1'b0; stallreq_id = 1'b0; settle();
        chk("div_after_done", 32'(ex_mc_done), 32'h0);
        chk("div_after_stall", 32'(stall), 32'h00);
        // madd: EX hold 1 cycle, done on cycle 2, held request not restarted
        tick();
        ex_mc_req = 1'b1; ex_mc_is_div = 1'b0; settle();
        chk("madd_c1_stall", 32'(stall), 32'h0F);
        chk("madd_c1_done", 32'(ex_mc_done), 32'h0);
        tick(); settle();
        chk("madd_done", 32'(ex_mc_done), 32'h1);
        chk("madd_done_stall", 32'(stall), 32'h00);
        tick(); ex_mc_req = 1'b0; settle();
        chk("madd_after_done", 32'(ex_mc_done), 32'h0);
        chk("madd_after_stall", 32'(stall), 32'h00);
        // flush aborts a div at BUSY cycle 10
        tick();
        ex_mc_req = 1'b1; ex_mc_is_div = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        flush_req = 1'b1; flush_pc = 32'hBFC00380; settle();
        chk("abort_flush", 32'(flush), 32'h1);
        chk("abort_done", 32'(ex_mc_done), 32'h0);
        chk("abort_phase", 32'(ex_mc_phase), 32'd22);
        tick(); flush_req = 1'b0; ex_mc_req = 1'b0; settle();
        chk("abort_new_pc", new_pc, 32'hBFC00380);
        chk("abort_fl_flush", 32'(flush), 32'h0);
        chk("abort_fl_stall", 32'(stall), 32'h00);
        chk("abort_fl_phase", 32'(ex_mc_phase), 32'h0);
        chk("abort_fl_done", 32'(ex_mc_done), 32'h0);
        tick(); stallreq_id = 1'b1; settle();
        chk("abort_idle_stall", 32'(stall), 32'h07);
        chk("abort_idle_done", 32'(ex_mc_done), 32'h0);
        stallreq_id = 1'b0;
        // back-to-back flush pulses: second ignored in FLUSH, accepted in IDLE
        tick(); flush_req = 1'b1; flush_pc = 32'h80000180; settle();
        chk("b2b_first", 32'(flush), 32'h1);
        tick(); flush_pc = 32'h11111111; settle();
        chk("b2b_in_flush", 32'(flush), 32'h0);
        chk("b2b_pc1", new_pc, 32'h80000180);
        tick(); flush_pc = 32'h22222222; settle();
        chk("b2b_second", 32'(flush), 32'h1);
        tick(); flush_req = 1'b0; settle();
        chk("b2b_pc2", new_pc, 32'h22222222);
        // flush + ex req + ID req in the same IDLE cycle: flush wins
        tick();
        flush_req = 1'b1; ex_mc_req = 1'b1; stallreq_id = 1'b1; flush_pc = 32'hA5A5A5A4; settle();
        chk("prio_flush", 32'(flush), 32'h1);
        chk("prio_stall", 32'(stall), 32'h00);
        tick(); flush_req = 1'b0; ex_mc_req = 1'b0; stallreq_id = 1'b0; settle();
        chk("prio_new_pc", new_pc, 32'hA5A5A5A4);
        tick(); settle();
        chk("prio_idle_phase", 32'(ex_mc_phase), 32'h0);
        chk("prio_idle_stall", 32'(stall), 32'h00);
        // flush arriving in DONE suppresses the done strobe
        ex_mc_req = 1'b1; ex_mc_is_div = 1'b0;
        tick(); ex_mc_req = 1'b0; flush_req = 1'b1; flush_pc = 32'h00000ABC; settle();
        chk("done_flush", 32'(flush), 32'h1);
        chk("done_flush_done", 32'(ex_mc_done), 32'h0);
        tick(); flush_req = 1'b0; settle();
        chk("done_flush_pc", new_pc, 32'h00000ABC);
        // reset mid-BUSY: outputs forced low, no done afterwards
        tick(); ex_mc_req = 1'b1; ex_mc_is_div = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1; settle();
        chk("rst_busy_stall", 32'(stall), 32'h00);
        tick(); rst = 1'b0; ex_mc_req = 1'b0; settle();
        chk("rst_busy_phase", 32'(ex_mc_phase), 32'h0);
        chk("rst_busy_pc", new_pc, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy_no_done", 32'(ex_mc_done), 32'h0);
            chk("rst_busy_nostall", 32'(stall), 32'h00);
            tick(); settle();
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
